// File: rtl/cdc_pkg.sv
// Shared types and constants for the four-phase req/ack CDC handshake pair.
package cdc_pkg;

  localparam int CDC_MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } cdc_hs_state_e;

endpackage

// File: rtl/cdc_hs_tx_sync_bit.sv
// Generic N-stage single-bit synchronizer, async active-low reset, flops reset to 0.
module sync_bit
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_stages
    $error("sync_bit: STAGES below CDC_MIN_SYNC_STAGES");
  end

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a four-phase req/ack word transfer into another clock domain.
// Optional sticky ack-timeout flag built when CDC_HS_TX_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | req_o low, waiting for a word (and for a stale ack to clear)
// REQ   | req_o high, data_o held, waiting for synchronized ack to rise
// DROP  | req_o low, waiting for synchronized ack to fall
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_a,
  input  logic              rst_a_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              busy,
  output logic              timeout_err
);

  if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_sync
    $error("cdc_hs_tx: SYNC_STAGES below CDC_MIN_SYNC_STAGES");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("cdc_hs_tx: TIMEOUT_CYC must be at least 2");
  end

  logic ack_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk_a),
    .rst_n (rst_a_n),
    .d     (ack_i),
    .q     (ack_s)
  );

  cdc_hs_state_e     state_q, state_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign in_ready = (state_q == IDLE) && !ack_s;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    busy_d  = busy_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        state_d = REQ;
        req_d   = 1'b1;
        busy_d  = 1'b1;
        data_d  = in_data;
      end
      REQ: if (ack_s) begin
        state_d = DROP;
        req_d   = 1'b0;
      end
      DROP: if (!ack_s) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  assign req_o  = req_q;
  assign busy   = busy_q;
  assign data_o = data_q;

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             wait_entry;

  // Observe only: the FSM keeps waiting regardless of the flag.
  assign wait_entry = (state_d != state_q) && (state_d != IDLE);

  always_comb begin
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (wait_entry)            cnt_d = '0;
    else if (state_q != IDLE)  cnt_d = cnt_q + CNT_W'(1);
    if ((state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) tmo_d = 1'b1;
  end

  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Scoreboard bench for cdc_hs_tx: loopback and manual ack, stale ack, hold, reset, timeout.
module tb_cdc_hs_tx;
  localparam int DATA_W = 8;
  localparam int S      = 2;
  localparam int TMO    = 16;

  logic              clk_a   = 1'b0;
  logic              rst_a_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic              ack_man  = 1'b0;
  logic              loop_en  = 1'b0;
  logic              ack_i;
  logic              in_ready, req_o, busy, timeout_err;
  logic [DATA_W-1:0] data_o;

  int n_cmp = 0;
  int n_err = 0;
  int req_rises = 0;
  logic [DATA_W-1:0] exp_q[$];

  assign ack_i = loop_en ? req_o : ack_man;

  cdc_hs_tx #(.DATA_W(DATA_W), .SYNC_STAGES(S), .TIMEOUT_CYC(TMO)) dut (
    .clk_a       (clk_a),
    .rst_a_n     (rst_a_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .req_o       (req_o),
    .data_o      (data_o),
    .ack_i       (ack_i),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk_a = ~clk_a;
  always @(posedge req_o) req_rises++;

  task automatic step();
    @(posedge clk_a);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_a_n  = 1'b0;
    step();
    step();
    rst_a_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    loop_en = 1'b0;
    ack_man = 1'b0;
    do_reset();
    n_cmp++; if (req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", req_o); end
    n_cmp++; if (data_o !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", data_o); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_tmo: got %b want 0", timeout_err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_loopback_a5();
    logic [DATA_W-1:0] e;
    int first_low, first_rdy;
    do_reset();
    loop_en = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL a5_pre_ready: got %b want 1", in_ready); end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    step();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    e = exp_q.pop_front();
    n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL a5_data: got %h want %h", data_o, e); end
    n_cmp++; if (req_o !== 1'b1) begin n_err++; $display("FAIL a5_req: got %b want 1", req_o); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL a5_ready_after: got %b want 0", in_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL a5_busy: got %b want 1", busy); end
    first_low = -1;
    first_rdy = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first_low < 0 && req_o === 1'b0) first_low = k;
      if (first_rdy < 0 && in_ready === 1'b1) first_rdy = k;
      if (first_rdy >= 0) break;
    end
    n_cmp++; if (first_low != 3) begin n_err++; $display("FAIL a5_req_len: got %0d want 3", first_low); end
    n_cmp++; if (first_rdy != 2*S+2) begin n_err++; $display("FAIL a5_ready_lat: got %0d want %0d", first_rdy, 2*S+2); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL a5_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] e;
    logic acc;
    int idx, last, cyc, base;
    loop_en = 1'b1;
    base = req_rises;
    for (int w = 1; w <= 4; w++) exp_q.push_back(DATA_W'(w));
    idx = 0; last = -1; cyc = 0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    while (idx < 4 && cyc < 80) begin
      acc = in_ready && in_valid;
      step();
      cyc++;
      if (acc) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", idx, data_o, e); end
        n_cmp++; if (req_o !== 1'b1) begin n_err++; $display("FAIL stream_req[%0d]: got %b want 1", idx, req_o); end
        if (last >= 0) begin
          n_cmp++; if (cyc - last != 2*S+3) begin n_err++; $display("FAIL stream_spacing[%0d]: got %0d want %0d", idx, cyc - last, 2*S+3); end
        end
        last = cyc;
        idx++;
        if (idx < 4) in_data = DATA_W'(idx + 1);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (idx != 4) begin n_err++; $display("FAIL stream_done: got %0d accepts want 4", idx); end
    repeat (10) step();
    n_cmp++; if (req_rises - base != 4) begin n_err++; $display("FAIL stream_req_count: got %0d want 4", req_rises - base); end
    exp_q.delete();
  endtask

  task automatic test_stale_ack();
    int base;
    loop_en = 1'b0;
    ack_man = 1'b1;
    in_valid = 1'b0;
    rst_a_n = 1'b0;
    step();
    step();
    base = req_rises;
    rst_a_n = 1'b1;
    repeat (3) step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stale_ready: got %b want 0", in_ready); end
    in_valid = 1'b1;
    in_data  = 8'h3C;
    repeat (4) step();
    n_cmp++; if (req_o !== 1'b0) begin n_err++; $display("FAIL stale_req: got %b want 0", req_o); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stale_busy: got %b want 0", busy); end
    ack_man = 1'b0;
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stale_ready_1: got %b want 0", in_ready); end
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stale_ready_2: got %b want 1", in_ready); end
    in_valid = 1'b0;
    n_cmp++; if (data_o !== 8'h00) begin n_err++; $display("FAIL stale_data: got %h want 00", data_o); end
    n_cmp++; if (req_rises != base) begin n_err++; $display("FAIL stale_pulse: got %0d rises want 0", req_rises - base); end
  endtask

  task automatic test_data_hold();
    logic [DATA_W-1:0] e;
    bit seen;
    loop_en = 1'b0;
    ack_man = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    exp_q.push_back(8'h5A);
    step();
    in_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hold_accept: got %h want %h", data_o, e); end
    for (int k = 0; k < 6; k++) begin
      in_data  = DATA_W'($urandom);
      in_valid = 1'($urandom);
      step();
      n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hold_req[%0d]: got %h want %h", k, data_o, e); end
      n_cmp++; if (req_o !== 1'b1) begin n_err++; $display("FAIL hold_reqlvl[%0d]: got %b want 1", k, req_o); end
    end
    in_valid = 1'b0;
    ack_man = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      in_data = DATA_W'($urandom);
      step();
      n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hold_ack[%0d]: got %h want %h", k, data_o, e); end
      if (req_o === 1'b0) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL hold_req_fall: got req %b want 0 within 10", req_o); end
    ack_man = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      in_data = DATA_W'($urandom);
      step();
      n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hold_drop[%0d]: got %h want %h", k, data_o, e); end
      if (in_ready === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL hold_ready: got %b want 1 within 10", in_ready); end
    in_valid = 1'b1;
    in_data  = 8'h96;
    exp_q.push_back(8'h96);
    step();
    in_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hold_next: got %h want %h", data_o, e); end
    ack_man = 1'b1;
    repeat (4) step();
    ack_man = 1'b0;
    repeat (4) step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_idle: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    loop_en = 1'b0;
    ack_man = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    step();
    in_valid = 1'b0;
    n_cmp++; if (req_o !== 1'b1) begin n_err++; $display("FAIL mid_req_pre: got %b want 1", req_o); end
    #3 rst_a_n = 1'b0;
    #1;
    n_cmp++; if (req_o !== 1'b0) begin n_err++; $display("FAIL mid_req: got %b want 0", req_o); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (data_o !== 8'h00) begin n_err++; $display("FAIL mid_data: got %h want 00", data_o); end
    #2 rst_a_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_timeout();
    loop_en = 1'b0;
    ack_man = 1'b0;
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    in_valid = 1'b0;
`ifdef CDC_HS_TX_TIMEOUT_EN
    begin
      int first;
      first = -1;
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", timeout_err); end
      for (int k = 1; k <= 30; k++) begin
        step();
        if (timeout_err === 1'b1) begin first = k; break; end
      end
      n_cmp++; if (first != TMO) begin n_err++; $display("FAIL tmo_cycle: got %0d want %0d", first, TMO); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL tmo_busy: got %b want 1", busy); end
      ack_man = 1'b1;
      repeat (5) step();
      ack_man = 1'b0;
      repeat (5) step();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL tmo_done: got %b want 1", in_ready); end
      n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
      do_reset();
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_clear: got %b want 0", timeout_err); end
    end
`else
    repeat (30) step();
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_off: got %b want 0", timeout_err); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL tmo_off_busy: got %b want 1", busy); end
    ack_man = 1'b1;
    repeat (5) step();
    ack_man = 1'b0;
    repeat (5) step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL tmo_off_done: got %b want 1", in_ready); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback_a5();
    test_stream();
    test_stale_ack();
    test_data_hold();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
